// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED-matrix tile link: geometry, pixel layout and
// the receiver state encoding.
package led_matrix_pkg;

  localparam int MATRIX_COLS = 16;
  localparam int MATRIX_ROWS = 8;
  localparam int COLOR_BITS  = 8;

  typedef struct packed {
    logic [COLOR_BITS-1:0] r;
    logic [COLOR_BITS-1:0] g;
    logic [COLOR_BITS-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_FLUSH
  } spi_rx_state_e;

  function automatic int pixel_index(input int row, input int col);
    return row * MATRIX_COLS + col;
  endfunction

endpackage

// File: rtl/spi_tile_receiver_if.sv
// Tile link bundle: SPI pins toward the receiver, pixel/frame strobes back out.
interface spi_tile_receiver_if #(
  parameter int PIXELS     = 128,
  parameter int COLOR_BITS = led_matrix_pkg::COLOR_BITS
);
  logic                      spi_clk;
  logic                      spi_mosi;
  logic                      sel_n;
  logic                      pix_valid;
  logic [$clog2(PIXELS)-1:0] pix_addr;
  logic [3*COLOR_BITS-1:0]   pix_rgb;
  logic                      frame_done;
  logic                      frame_err;
  logic                      busy;

  modport slave (
    input  spi_clk, spi_mosi, sel_n,
    output pix_valid, pix_addr, pix_rgb, frame_done, frame_err, busy
  );

  modport master (
    output spi_clk, spi_mosi, sel_n,
    input  pix_valid, pix_addr, pix_rgb, frame_done, frame_err, busy
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pins, with a configurable reset value
// so inactive-high inputs come out of reset deasserted.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking so each stage samples the previous stage's old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/spi_tile_receiver.sv
// Oversampling SPI receiver for one LED tile: turns the serial stream into
// per-pixel write strobes and reports frame completion or abort.
module spi_tile_receiver #(
  parameter int PIXELS         = 128,
  parameter int COLOR_BITS     = led_matrix_pkg::COLOR_BITS,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  spi_tile_receiver_if.slave  bus
);
  import led_matrix_pkg::*;

  localparam int PIX_W = 3 * COLOR_BITS;
  localparam int AW    = $clog2(PIXELS);
  localparam int BW    = $clog2(PIX_W);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW-1:0] LAST_PIX = AW'(PIXELS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(PIX_W - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0] pins_s;
  logic       sel_s;
  logic       spi_clk_d, rise, mosi_d;

  sync_2ff #(.WIDTH(2), .RESET_VAL(2'b00)) u_sync_spi (
    .clk (clk), .rst (rst), .d ({bus.spi_clk, bus.spi_mosi}), .q (pins_s)
  );
  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_sel (
    .clk (clk), .rst (rst), .d (bus.sel_n), .q (sel_s)
  );

  // Registered edge detect; mosi is delayed alongside so it lines up with rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_clk_d <= 1'b0;
      rise      <= 1'b0;
      mosi_d    <= 1'b0;
    end else begin
      spi_clk_d <= pins_s[1];
      rise      <= pins_s[1] & ~spi_clk_d;
      mosi_d    <= pins_s[0];
    end
  end

  spi_rx_state_e    state, state_n;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic [AW-1:0]    pix_cnt, pix_n;
  logic [TW-1:0]    tcnt, t_n;
  logic [PIX_W-1:0] shreg, sh_n;
  logic [PIX_W-1:0] rgb_q, rgb_n;
  logic [AW-1:0]    addr_q, addr_n;
  logic             valid_q, valid_n, done_q, done_n, err_q, err_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      pix_cnt <= '0;
      tcnt    <= '0;
      shreg   <= '0;
      rgb_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_n;
      pix_cnt <= pix_n;
      tcnt    <= t_n;
      shreg   <= sh_n;
      rgb_q   <= rgb_n;
      addr_q  <= addr_n;
      valid_q <= valid_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    pix_n   = pix_cnt;
    t_n     = tcnt;
    sh_n    = shreg;
    rgb_n   = rgb_q;
    addr_n  = addr_q;
    valid_n = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        bit_n = '0;
        pix_n = '0;
        t_n   = '0;
        if (!sel_s) state_n = ST_RECV;
      end
      ST_RECV: begin
        t_n = tcnt + 1'b1;
        if (rise) begin
          t_n  = '0;
          sh_n = {shreg[PIX_W-2:0], mosi_d};
          if (bit_cnt == LAST_BIT) begin
            bit_n   = '0;
            valid_n = 1'b1;
            rgb_n   = sh_n;
            addr_n  = pix_cnt;
            pix_n   = pix_cnt + 1'b1;
            done_n  = (pix_cnt == LAST_PIX);
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
        // A frame that just completed wins over a simultaneous deselect.
        if (done_n) begin
          state_n = sel_s ? ST_IDLE : ST_FLUSH;
        end else if (sel_s) begin
          state_n = ST_IDLE;
          err_n   = (bit_n != '0) || (pix_n != '0);
        end else if (!rise && tcnt == T_LAST) begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (sel_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.pix_valid  = valid_q;
  assign bus.pix_addr   = addr_q;
  assign bus.pix_rgb    = rgb_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = (state != ST_IDLE);
endmodule
